// File: rtl/ps2_key_rx_pkg.sv
// Shared scan-code constants and frame FSM state encoding for the PS/2 key receiver.
package ps2_key_rx_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_DECODE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/ps2_key_if.sv
// Key event bundle from the PS/2 receiver to the game top level.
interface ps2_key_if;

    logic [7:0] key_code;
    logic       key_valid;
    logic       key_break;
    logic       key_ext;
    logic       flap;
    logic       frame_err;

    modport master (
        output key_code, key_valid, key_break, key_ext, flap, frame_err
    );

    modport slave (
        input key_code, key_valid, key_break, key_ext, flap, frame_err
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: 2-flop sync, FILTER_LEN-deep level filter, falling-edge pulse.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic mclk,
    input  logic clr_n,
    input  logic ps2c,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] shreg;
    logic                  filt;
    logic                  filt_d;

    // Level only moves once the whole window agrees; anything shorter is a glitch.
    always_comb begin
        filt_d = filt;
        if (&shreg)
            filt_d = 1'b1;
        else if (~|shreg)
            filt_d = 1'b0;
    end

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            sync  <= '1;
            shreg <= '1;
            filt  <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], ps2c};
            shreg <= {shreg[FILTER_LEN-2:0], sync[1]};
            filt  <= filt_d;
            fall  <= filt & ~filt_d;
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, tracks E0/F0 prefixes, emits key events.
//
// state  | meaning
// IDLE   | line idle, waiting for start bit edge
// RECV   | shifting in 8 data bits LSB-first
// PARITY | waiting for parity bit edge
// STOP   | waiting for stop bit edge, then frame check
// DECODE | one cycle: prefix tracking or key event
module ps2_key_rx
    import ps2_key_rx_pkg::*;
#(
    parameter int         FILTER_LEN = 8,
    parameter int         TIMEOUT    = 100000,
    parameter logic [7:0] FLAP_CODE  = SC_SPACE
) (
    input  logic       mclk,
    input  logic       clr_n,
    input  logic       PS2C,
    input  logic       PS2D,
    ps2_key_if.master  key
);

    localparam int              TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT - 1);

    rx_state_t     state, state_d;
    logic          ps2c_fall;
    logic [1:0]    ps2d_sync;
    logic          ps2d_s;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    data, data_d;
    logic          par, par_d;
    logic [TW-1:0] tmo, tmo_d;
    logic          ext_pend, ext_pend_d;
    logic          brk_pend, brk_pend_d;
    logic [7:0]    code_q, code_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          valid_d, flap_d, err_d;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .mclk  (mclk),
        .clr_n (clr_n),
        .ps2c  (PS2C),
        .fall  (ps2c_fall)
    );

    assign ps2d_s = ps2d_sync[1];

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        data_d     = data;
        par_d      = par;
        tmo_d      = tmo;
        ext_pend_d = ext_pend;
        brk_pend_d = brk_pend;
        code_d     = code_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        flap_d     = 1'b0;
        err_d      = 1'b0;

        // Down-counter reloads on each edge; terminal count of zero means the frame stalled.
        if (ps2c_fall || state == ST_IDLE)
            tmo_d = TMO_LOAD;
        else if (tmo != '0)
            tmo_d = tmo - 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (ps2c_fall) begin
                    if (!ps2d_s) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (ps2c_fall) begin
                    data_d    = {ps2d_s, data[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (ps2c_fall) begin
                    par_d   = ps2d_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (ps2c_fall) begin
                    if (ps2d_s && (^{data, par}))
                        state_d = ST_DECODE;
                    else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DECODE: begin
                if (data == SC_EXT)
                    ext_pend_d = 1'b1;
                else if (data == SC_BREAK)
                    brk_pend_d = 1'b1;
                else begin
                    code_d     = data;
                    brk_d      = brk_pend;
                    ext_d      = ext_pend;
                    valid_d    = 1'b1;
                    flap_d     = (data == FLAP_CODE) && !brk_pend && !ext_pend;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state == ST_RECV || state == ST_PARITY || state == ST_STOP)
            && !ps2c_fall && tmo == '0) begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            state         <= ST_IDLE;
            ps2d_sync     <= '1;
            bit_cnt       <= '0;
            data          <= '0;
            par           <= 1'b0;
            tmo           <= '0;
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
            code_q        <= '0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            key.key_valid <= 1'b0;
            key.flap      <= 1'b0;
            key.frame_err <= 1'b0;
        end else begin
            state         <= state_d;
            ps2d_sync     <= {ps2d_sync[0], PS2D};
            bit_cnt       <= bit_cnt_d;
            data          <= data_d;
            par           <= par_d;
            tmo           <= tmo_d;
            ext_pend      <= ext_pend_d;
            brk_pend      <= brk_pend_d;
            code_q        <= code_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            key.key_valid <= valid_d;
            key.flap      <= flap_d;
            key.frame_err <= err_d;
        end
    end

    assign key.key_code  = code_q;
    assign key.key_break = brk_q;
    assign key.key_ext   = ext_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: directed scenarios plus randomized frames vs a prefix model.
module tb_ps2_key_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 20;

    logic mclk = 1'b0;
    logic clr_n = 1'b0;
    logic PS2C = 1'b1;
    logic PS2D = 1'b1;

    ps2_key_if kif ();

    ps2_key_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .FLAP_CODE  (8'h29)
    ) dut (
        .mclk  (mclk),
        .clr_n (clr_n),
        .PS2C  (PS2C),
        .PS2D  (PS2D),
        .key   (kif)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int failures = 0;

    // Event log sampled on the falling clock edge: {code, break, ext}.
    logic [9:0] obs_q[$];
    int n_flap = 0;
    int n_err = 0;
    int n_flap_bad = 0;

    always @(negedge mclk) begin
        if (kif.key_valid) obs_q.push_back({kif.key_code, kif.key_break, kif.key_ext});
        if (kif.flap) n_flap++;
        if (kif.frame_err) n_err++;
        if (kif.flap && !kif.key_valid) n_flap_bad++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge mclk);
    endtask

    // Drive the first nbits of an 11-bit frame (bit 0 first), device-clocked.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            PS2D = bits[i];
            wait_cyc(half);
            PS2C = 1'b0;
            wait_cyc(half);
            PS2C = 1'b1;
        end
        wait_cyc(half);
        PS2D = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop
    function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
        logic p;
        logic s;
        p = ~(^b);
        if (kind == 1) p = ~p;
        s = (kind == 2) ? 1'b0 : 1'b1;
        return {s, p, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input int kind);
        send_bits(make_frame(b, kind), 11, HALF);
        wait_cyc(30);
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        wait_cyc(5);
        @(negedge mclk);
        checks++;
        if ({kif.key_code, kif.key_valid, kif.key_break, kif.key_ext, kif.flap, kif.frame_err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0",
                     {kif.key_code, kif.key_valid, kif.key_break, kif.key_ext, kif.flap, kif.frame_err});
        end
        clr_n = 1'b1;
        wait_cyc(40);
        checks++;
        if (obs_q.size() != 0 || n_err != 0 || n_flap != 0) begin
            failures++;
            $display("FAIL reset_release_pulse: valid=%0d err=%0d flap=%0d want 0 0 0", obs_q.size(), n_err, n_flap);
        end
    endtask

    task automatic test_space_make();
        int b0 = obs_q.size();
        int f0 = n_flap;
        int e0 = n_err;
        send_frame(8'h29, 0);
        checks++;
        if (obs_q.size() - b0 != 1) begin
            failures++;
            $display("FAIL make_count: got %0d want 1", obs_q.size() - b0);
        end else begin
            checks++;
            if (obs_q[b0] !== {8'h29, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL make_event: got %h want %h", obs_q[b0], {8'h29, 2'b00});
            end
        end
        checks++;
        if (n_flap - f0 != 1 || n_err != e0) begin
            failures++;
            $display("FAIL make_flap: flap=%0d err=%0d want 1 0", n_flap - f0, n_err - e0);
        end
    endtask

    task automatic test_space_release();
        int b0 = obs_q.size();
        int f0 = n_flap;
        send_frame(8'hF0, 0);
        checks++;
        if (obs_q.size() != b0) begin
            failures++;
            $display("FAIL release_prefix_pulse: got %0d events want 0", obs_q.size() - b0);
        end
        send_frame(8'h29, 0);
        checks++;
        if (obs_q.size() - b0 != 1 || obs_q[obs_q.size()-1] !== {8'h29, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL release_event: n=%0d last=%h want 1 %h", obs_q.size() - b0,
                     obs_q[obs_q.size()-1], {8'h29, 2'b10});
        end
        checks++;
        if (n_flap != f0) begin
            failures++;
            $display("FAIL release_flap: got %0d want 0", n_flap - f0);
        end
    endtask

    task automatic test_ext_break();
        int b0 = obs_q.size();
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        checks++;
        if (obs_q.size() - b0 != 1 || obs_q[obs_q.size()-1] !== {8'h75, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL ext_break_event: n=%0d last=%h want 1 %h", obs_q.size() - b0,
                     obs_q[obs_q.size()-1], {8'h75, 2'b11});
        end
    endtask

    task automatic test_bad_frames();
        int b0 = obs_q.size();
        int e0 = n_err;
        send_frame(8'h1C, 1);
        checks++;
        if (n_err - e0 != 1 || obs_q.size() != b0) begin
            failures++;
            $display("FAIL bad_parity: err=%0d valid=%0d want 1 0", n_err - e0, obs_q.size() - b0);
        end
        send_frame(8'h1C, 2);
        checks++;
        if (n_err - e0 != 2 || obs_q.size() != b0) begin
            failures++;
            $display("FAIL bad_stop: err=%0d valid=%0d want 2 0", n_err - e0, obs_q.size() - b0);
        end
        send_frame(8'h1C, 0);
        checks++;
        if (obs_q.size() - b0 != 1 || obs_q[obs_q.size()-1] !== {8'h1C, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL after_bad_good: n=%0d last=%h want 1 %h", obs_q.size() - b0,
                     obs_q[obs_q.size()-1], {8'h1C, 2'b00});
        end
    endtask

    task automatic test_timeout_glitch();
        int b0 = obs_q.size();
        int e0 = n_err;
        int f0 = n_flap;
        send_frame(8'hE0, 0);
        send_bits(make_frame(8'h29, 0), 5, HALF);
        wait_cyc(TIMEOUT + 10);
        checks++;
        if (n_err - e0 != 1 || obs_q.size() != b0) begin
            failures++;
            $display("FAIL timeout: err=%0d valid=%0d want 1 0", n_err - e0, obs_q.size() - b0);
        end
        PS2D = 1'b1;
        PS2C = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        PS2C = 1'b1;
        wait_cyc(40);
        checks++;
        if (n_err - e0 != 1 || obs_q.size() != b0) begin
            failures++;
            $display("FAIL glitch: err=%0d valid=%0d want 1 0", n_err - e0, obs_q.size() - b0);
        end
        send_frame(8'h29, 0);
        checks++;
        if (obs_q.size() - b0 != 1 || n_flap - f0 != 1 || obs_q[obs_q.size()-1] !== {8'h29, 2'b00}) begin
            failures++;
            $display("FAIL timeout_clears_ext: n=%0d flap=%0d last=%h want 1 1 %h",
                     obs_q.size() - b0, n_flap - f0, obs_q[obs_q.size()-1], {8'h29, 2'b00});
        end
    endtask

    task automatic test_reset_mid_frame();
        int b0 = obs_q.size();
        int f0 = n_flap;
        int e0 = n_err;
        send_frame(8'hE0, 0);
        send_bits(make_frame(8'h75, 0), 4, HALF);
        clr_n = 1'b0;
        wait_cyc(4);
        @(negedge mclk);
        checks++;
        if ({kif.key_code, kif.key_valid, kif.key_break, kif.key_ext, kif.flap, kif.frame_err} !== 13'd0) begin
            failures++;
            $display("FAIL midframe_reset_outputs: got %h want 0",
                     {kif.key_code, kif.key_valid, kif.key_break, kif.key_ext, kif.flap, kif.frame_err});
        end
        clr_n = 1'b1;
        wait_cyc(40);
        send_frame(8'h29, 0);
        checks++;
        if (obs_q.size() - b0 != 1 || n_flap - f0 != 1 || n_err != e0
            || obs_q[obs_q.size()-1] !== {8'h29, 2'b00}) begin
            failures++;
            $display("FAIL midframe_recover: n=%0d flap=%0d err=%0d last=%h want 1 1 0 %h",
                     obs_q.size() - b0, n_flap - f0, n_err - e0, obs_q[obs_q.size()-1], {8'h29, 2'b00});
        end
    endtask

    // Reference: prefixes arm flags, errors leave them, any other good byte is an event.
    task automatic test_random();
        logic [9:0] exp_q[$];
        logic       m_ext = 1'b0;
        logic       m_brk = 1'b0;
        int         exp_err = 0;
        int         exp_flap = 0;
        int         b0 = obs_q.size();
        int         f0 = n_flap;
        int         e0 = n_err;
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b;
            int sel = int'($urandom_range(0, 5));
            int kind = int'($urandom_range(0, 5));
            int half = int'($urandom_range(15, 30));
            b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : (sel == 2) ? 8'h29 : 8'($urandom);
            if (i == 13) begin
                b = 8'h11;
                kind = 5;
            end
            if (kind > 1) kind = 0;
            else kind = kind + 1;
            send_bits(make_frame(b, kind), 11, half);
            wait_cyc(30);
            if (kind != 0) exp_err++;
            else if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                exp_q.push_back({b, m_brk, m_ext});
                if (b == 8'h29 && !m_brk && !m_ext) exp_flap++;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        checks++;
        if (obs_q.size() - b0 != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d want %0d", obs_q.size() - b0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[b0+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_event[%0d]: got %h want %h", i, obs_q[b0+i], exp_q[i]);
                end
            end
        end
        checks++;
        if (n_flap - f0 != exp_flap || n_err - e0 != exp_err) begin
            failures++;
            $display("FAIL random_pulses: flap=%0d err=%0d want %0d %0d",
                     n_flap - f0, n_err - e0, exp_flap, exp_err);
        end
        checks++;
        if (n_flap_bad != 0) begin
            failures++;
            $display("FAIL flap_without_valid: got %0d want 0", n_flap_bad);
        end
    endtask

    initial begin
        test_reset();
        test_space_make();
        test_space_release();
        test_ext_break();
        test_bad_frames();
        test_timeout_glitch();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
